// File: rtl/armv8_pkg.sv
// armv8_pkg: shared widths, PC step and fetch-entry layout for the ARMv8 front end
package armv8_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-handshake signals of the fetch unit
// master: fetch unit side (drives imem_req/imem_addr and the out_* head signals)
// slave:  memory + decode + redirect source side
interface fetch_unit_if #(
  parameter int ADDR_W  = armv8_pkg::ADDR_W,
  parameter int INSTR_W = armv8_pkg::INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc4;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush
// clk/rst: clock, sync active-high reset; push/in_data: write; pop/out_data: head read/advance
// flush: empty the queue (wins over push/pop); full/empty/count: occupancy
module fetch_queue #(
  parameter int  DEPTH = 4,
  parameter type T     = armv8_pkg::fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              in_data,
  output T              out_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T mem_q [DEPTH];
  T head_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full     = count_q == CW'(DEPTH);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // when empty, present the last head that left so outputs stay stable and defined
  assign out_data = empty ? head_q : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) head_q <= '0;
    else if (!empty && (do_pop || flush)) head_q <= mem_q[rd_q];
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer, fixed-latency imem issue and fetch queue toward decode
// clock/reset: clock, sync active-high reset
// bus (master): imem_req/imem_addr/imem_rdata memory port, redirect/redirect_pc flush port,
//               out_valid/out_ready/out_instr/out_pc/out_pc4 decode handshake
module fetch_unit #(
  parameter int                ADDR_W   = armv8_pkg::ADDR_W,
  parameter int                INSTR_W  = armv8_pkg::INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  import armv8_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic inflight_q, inflight_d, squash_q, squash_d;
  logic issue, push, pop, full, empty;
  logic [CW-1:0] count;
  entry_t head;
  // reserve a slot for every outstanding response so a push can never overflow
  assign issue = !reset && !bus.redirect && !full &&
                 (({1'b0, count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
  assign push  = inflight_q && !squash_q && !bus.redirect;
  assign pop   = bus.out_valid && bus.out_ready && !bus.redirect;
  always_comb begin
    fetch_pc_d = bus.redirect ? (bus.redirect_pc & ~ADDR_W'(3)) :
                 issue        ? fetch_pc_q + ADDR_W'(PC_STEP)     : fetch_pc_q;
    req_pc_d   = issue ? fetch_pc_q : req_pc_q;
    inflight_d = issue;
    squash_d   = bus.redirect && inflight_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end
  fetch_queue #(.DEPTH(DEPTH), .T(entry_t)) u_queue (
    .clk      (clock),
    .rst      (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect),
    .in_data  ('{pc: req_pc_q, instr: bus.imem_rdata}),
    .out_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );
  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  // sync reset only clears state at the edge, so hide the head during the reset cycle itself
  assign bus.out_valid = !empty && !reset;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.out_pc4   = head.pc + ADDR_W'(PC_STEP);
endmodule
